// File: rtl/j_jmemarb_if.sv
// Memory arbiter bus bundle: two requester ports, memory-controller port, bus ownership.
// Latency: none (wiring only).
// Backpressure: requesters hold req until ack; the controller paces cycles with mack; busgnt gates external ownership.
//
// Ports grouped here:
//   requesters : req_n, rw_n, siz_n, addr_n, wdata_0 -> ack_n, rdata
//   controller : mreq, mrw, msiz, maddr, mwdata -> mack, mrdata
//   ownership  : busreq -> busgnt
// Modport slave is the arbiter's view; modport master is the surrounding system
// (DSP core, prefetch queue, memory controller and bus arbiter together).
interface j_jmemarb_if #(
    parameter int AW = 24
);
    logic          req_0;
    logic          req_1;
    logic          rw_0;
    logic          rw_1;
    logic [1:0]    siz_0;
    logic [1:0]    siz_1;
    logic [AW-1:0] addr_0;
    logic [AW-1:0] addr_1;
    logic [31:0]   wdata_0;
    logic          ack_0;
    logic          ack_1;
    logic [31:0]   rdata;
    logic          mreq;
    logic          mrw;
    logic [1:0]    msiz;
    logic [AW-1:0] maddr;
    logic [31:0]   mwdata;
    logic          mack;
    logic [31:0]   mrdata;
    logic          busreq;
    logic          busgnt;

    modport slave (
        input  req_0, req_1, rw_0, rw_1, siz_0, siz_1, addr_0, addr_1, wdata_0,
        output ack_0, ack_1, rdata,
        output mreq, mrw, msiz, maddr, mwdata,
        input  mack, mrdata,
        output busreq,
        input  busgnt
    );

    modport master (
        output req_0, req_1, rw_0, rw_1, siz_0, siz_1, addr_0, addr_1, wdata_0,
        input  ack_0, ack_1, rdata,
        input  mreq, mrw, msiz, maddr, mwdata,
        output mack, mrdata,
        input  busreq,
        output busgnt
    );
endinterface

// File: rtl/j_jmemarb.sv
// Arbitrates DSP data (port 0) and prefetch (port 1) onto one memory-controller port, acquiring the external bus and splitting longs on a 16-bit bus.
// Latency: grant-to-ack = 1 + busgnt wait + controller latency (+ second half when split) + 1 cycles.
// Backpressure: requests are held until ack; each cycle waits for mack; external cycles wait for busgnt.
//
// Ports: sys_clk, reset (async, active-high); dsp16 = 16-bit external bus, bigend = half ordering;
//        bus (j_jmemarb_if.slave) carries requester, memory-controller and bus-ownership signals.
module j_jmemarb #(
    parameter int         AW       = 24,
    parameter int         STARVE   = 4,
    parameter logic [8:0] INT_PAGE = 9'h1E2
) (
    input  logic         sys_clk,
    input  logic         reset,
    input  logic         dsp16,
    input  logic         bigend,
    j_jmemarb_if.slave   bus
);
    localparam int CW = $clog2(STARVE + 1);

    typedef enum logic [2:0] {IDLE, BUSREQ, ISSUE, HALF2, DONE} state_t;

    state_t        state, state_n;
    logic          sel_r;        // port that owns the current transfer
    logic          rw_r;
    logic [1:0]    siz_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   wdata_r;
    logic [31:0]   rdata_r;
    logic          split_r;      // long access going out as two 16-bit halves
    logic          bigend_r;
    logic          busreq_r;
    logic [CW-1:0] starve_cnt;

    logic          grant_vld;
    logic          grant_sel;
    logic          win_int;
    logic          win_rw;
    logic [1:0]    win_siz;
    logic [AW-1:0] win_addr;
    logic          issuing;
    logic [15:0]   half_w;

    // Candidate winner: port 1 only when alone or when port 0 has used up its streak.
    always_comb begin
        grant_sel = bus.req_1 && (!bus.req_0 || starve_cnt == CW'(STARVE));
        win_addr  = grant_sel ? bus.addr_1 : bus.addr_0;
        win_siz   = grant_sel ? bus.siz_1  : bus.siz_0;
        win_rw    = grant_sel ? 1'b1       : bus.rw_0;   // prefetch is read-only
        win_int   = (win_addr[AW-1 -: 9] == INT_PAGE);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        grant_vld = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_0 || bus.req_1) begin
                    grant_vld = 1'b1;
                    // Internal space needs no bus; an already-owned bus skips the request phase.
                    if (win_int || (bus.busgnt && busreq_r)) state_n = ISSUE;
                    else                                     state_n = BUSREQ;
                end
            end
            BUSREQ:  if (bus.busgnt) state_n = ISSUE;
            ISSUE:   if (bus.mack)   state_n = split_r ? HALF2 : DONE;
            HALF2:   if (bus.mack)   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sel_r      <= 1'b0;
            rw_r       <= 1'b0;
            siz_r      <= 2'b00;
            addr_r     <= '0;
            wdata_r    <= '0;
            rdata_r    <= '0;
            split_r    <= 1'b0;
            bigend_r   <= 1'b0;
            busreq_r   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (!bus.req_1)
                starve_cnt <= '0;
            else if (grant_vld)
                starve_cnt <= grant_sel ? '0 :
                              (starve_cnt == CW'(STARVE)) ? starve_cnt : starve_cnt + CW'(1);

            if (grant_vld) begin
                sel_r    <= grant_sel;
                rw_r     <= win_rw;
                siz_r    <= win_siz;
                addr_r   <= win_addr;
                wdata_r  <= grant_sel ? 32'h0 : bus.wdata_0;
                split_r  <= dsp16 && !win_int && (win_siz == 2'b10);
                bigend_r <= bigend;
                rdata_r  <= 32'h0;
            end

            // Ownership is decided in IDLE: keep/raise it for an external winner, release otherwise.
            if (state == IDLE)
                busreq_r <= grant_vld && !win_int;

            if (bus.mack && rw_r) begin
                if (state == ISSUE) begin
                    if (!split_r)      rdata_r         <= bus.mrdata;
                    else if (bigend_r) rdata_r[31:16]  <= bus.mrdata[15:0];
                    else               rdata_r[15:0]   <= bus.mrdata[15:0];
                end else if (state == HALF2) begin
                    if (bigend_r) rdata_r[15:0]  <= bus.mrdata[15:0];
                    else          rdata_r[31:16] <= bus.mrdata[15:0];
                end
            end
        end
    end

    assign issuing = (state == ISSUE) || (state == HALF2);
    // Upper half goes first when big-endian, second otherwise.
    assign half_w  = ((state == ISSUE) == bigend_r) ? wdata_r[31:16] : wdata_r[15:0];

    assign bus.mreq   = issuing;
    assign bus.mrw    = issuing && rw_r;
    assign bus.msiz   = !issuing ? 2'b00 : (split_r ? 2'b01 : siz_r);
    assign bus.maddr  = (state == ISSUE) ? addr_r :
                        (state == HALF2) ? addr_r + AW'(2) : '0;
    assign bus.mwdata = (!issuing || rw_r) ? 32'h0 :
                        (split_r ? {16'h0, half_w} : wdata_r);
    assign bus.ack_0  = (state == DONE) && !sel_r;
    assign bus.ack_1  = (state == DONE) &&  sel_r;
    assign bus.rdata  = (state == DONE) ? rdata_r : 32'h0;
    assign bus.busreq = busreq_r;
endmodule

// File: tb/tb_j_jmemarb.sv
module tb_j_jmemarb;
    localparam int STARVE = 4;

    logic sys_clk;
    logic reset;
    logic dsp16;
    logic bigend;

    j_jmemarb_if #(.AW(24)) bus ();

    j_jmemarb #(.AW(24), .STARVE(STARVE), .INT_PAGE(9'h1E2)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .dsp16   (dsp16),
        .bigend  (bigend),
        .bus     (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    // ---------------- memory controller model ----------------
    int          mem_lat = 1;
    bit          mem_rand_lat = 0;
    bit          spur = 0;
    bit          use_fix = 0;
    logic [31:0] rd_fix = 32'h0;
    logic [23:0] cq_addr[$];
    logic [1:0]  cq_siz[$];
    logic        cq_rw[$];
    logic        cq_breq[$];
    logic [31:0] cq_wd[$];
    logic [31:0] cq_rd[$];

    initial begin
        int wait_n;
        bit busy;
        busy = 0;
        wait_n = 0;
        bus.mack = 1'b0;
        bus.mrdata = 32'h0;
        forever begin
            @(negedge sys_clk);
            if (bus.mack) begin
                bus.mack = 1'b0;
                busy = 0;
            end else if (bus.mreq) begin
                if (!busy) begin
                    busy = 1;
                    wait_n = mem_rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
                    cq_addr.push_back(bus.maddr);
                    cq_siz.push_back(bus.msiz);
                    cq_rw.push_back(bus.mrw);
                    cq_breq.push_back(bus.busreq);
                    cq_wd.push_back(bus.mwdata);
                end
                if (wait_n == 0) begin
                    bus.mack = 1'b1;
                    bus.mrdata = use_fix ? rd_fix : $urandom;
                    cq_rd.push_back(bus.mrdata);
                end else begin
                    wait_n--;
                end
            end else begin
                busy = 0;
                if (spur) begin
                    bus.mack = 1'b1;
                    bus.mrdata = $urandom;
                    spur = 0;
                end
            end
        end
    end

    // ---------------- external bus arbiter model ----------------
    int gnt_delay = 0;
    bit steal = 0;

    initial begin
        int c;
        c = 0;
        bus.busgnt = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!bus.busreq || steal) begin
                bus.busgnt = 1'b0;
                c = 0;
            end else if (c >= gnt_delay) begin
                bus.busgnt = 1'b1;
            end else begin
                c++;
            end
        end
    end

    // ---------------- ack monitor ----------------
    int ack_port[$];
    int busreq_low = 0;

    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (!bus.busreq) busreq_low++;
            if (bus.ack_0 || bus.ack_1) begin
                n_cmp++;
                if ((bus.ack_0 && bus.ack_1) || (bus.ack_0 && !bus.req_0) || (bus.ack_1 && !bus.req_1)) begin
                    n_bad++;
                    $display("FAIL ack_sanity: ack_0=%b ack_1=%b req_0=%b req_1=%b, required a single ack to a requesting port",
                             bus.ack_0, bus.ack_1, bus.req_0, bus.req_1);
                end
                if (bus.ack_0) ack_port.push_back(0);
                if (bus.ack_1) ack_port.push_back(1);
            end
        end
    end

    // ---------------- helpers (stimulus / model, no checking) ----------------
    function automatic bit is_int(input logic [23:0] a);
        return a[23:15] == 9'h1E2;
    endfunction

    function automatic logic [23:0] rand_ext();
        logic [23:0] a;
        a = 24'($urandom);
        if (a[23:15] == 9'h1E2) a[23] = ~a[23];
        return a;
    endfunction

    task automatic clear_q();
        cq_addr.delete(); cq_siz.delete(); cq_rw.delete();
        cq_breq.delete(); cq_wd.delete(); cq_rd.delete();
    endtask

    task automatic drive(input int p, input logic rw, input logic [1:0] siz,
                         input logic [23:0] a, input logic [31:0] wd);
        if (p == 0) begin
            bus.rw_0 = rw; bus.siz_0 = siz; bus.addr_0 = a; bus.wdata_0 = wd; bus.req_0 = 1'b1;
        end else begin
            bus.rw_1 = 1'b1; bus.siz_1 = siz; bus.addr_1 = a; bus.req_1 = 1'b1;
        end
    endtask

    task automatic wait_ack(input int p, input int budget, output logic [31:0] rd,
                            output int cyc, output bit ok);
        ok = 0; cyc = 0; rd = 32'h0;
        while (cyc < budget && !ok) begin
            @(negedge sys_clk);
            cyc++;
            if ((p == 0 && bus.ack_0) || (p == 1 && bus.ack_1)) begin
                ok = 1;
                rd = bus.rdata;
            end
        end
        if (p == 0) bus.req_0 = 1'b0;
        else        bus.req_1 = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_timeout port %0d: no ack seen, required ack within %0d cycles", p, budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_cmp++;
        if ({bus.mreq, bus.mrw, bus.msiz, bus.maddr, bus.mwdata, bus.ack_0, bus.ack_1, bus.rdata, bus.busreq} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: mreq=%b msiz=%b maddr=%h mwdata=%h ack=%b%b rdata=%h busreq=%b, required all 0",
                     bus.mreq, bus.msiz, bus.maddr, bus.mwdata, bus.ack_0, bus.ack_1, bus.rdata, bus.busreq);
        end
        reset = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_internal();
        logic [31:0] rd; int cyc; bit ok;
        dsp16 = 1'b1; bigend = 1'b1; mem_lat = 2; use_fix = 1; rd_fix = 32'h12345678;
        clear_q();
        drive(0, 1'b1, 2'b10, 24'hF10004, 32'h0);
        wait_ack(0, 40, rd, cyc, ok);
        n_cmp++;
        if (cyc !== mem_lat + 2) begin
            n_bad++; $display("FAIL int_latency: %0d cycles, required %0d", cyc, mem_lat + 2);
        end
        n_cmp++;
        if (cq_addr.size() !== 1) begin
            n_bad++; $display("FAIL int_ncyc: %0d memory cycles, required 1", cq_addr.size());
        end else begin
            n_cmp++;
            if ({cq_addr[0], cq_siz[0], cq_rw[0], cq_breq[0]} !== {24'hF10004, 2'b10, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL int_cycle: addr=%h siz=%b rw=%b busreq=%b, required F10004 10 1 0",
                         cq_addr[0], cq_siz[0], cq_rw[0], cq_breq[0]);
            end
        end
        n_cmp++;
        if (rd !== 32'h12345678) begin
            n_bad++; $display("FAIL int_rdata: %h, required 12345678", rd);
        end
        @(negedge sys_clk);
        n_cmp++;
        if ({bus.ack_0, bus.ack_1, bus.busreq} !== 3'b000) begin
            n_bad++; $display("FAIL int_ack_width: ack=%b%b busreq=%b after ack cycle, required 000",
                              bus.ack_0, bus.ack_1, bus.busreq);
        end
        use_fix = 0;
    endtask

    task automatic test_split_write();
        logic [31:0] rd; int cyc; bit ok;
        dsp16 = 1'b1; bigend = 1'b1; mem_lat = 1; gnt_delay = 3;
        clear_q(); ack_port.delete();
        drive(0, 1'b0, 2'b10, 24'h000100, 32'hAABBCCDD);
        wait_ack(0, 60, rd, cyc, ok);
        repeat (2) @(negedge sys_clk);
        n_cmp++;
        if (cq_addr.size() !== 2) begin
            n_bad++; $display("FAIL sw_ncyc: %0d memory cycles, required 2", cq_addr.size());
        end else begin
            n_cmp++;
            if ({cq_addr[0], cq_siz[0], cq_rw[0], cq_breq[0], cq_wd[0][15:0]} !== {24'h000100, 2'b01, 1'b0, 1'b1, 16'hAABB}) begin
                n_bad++; $display("FAIL sw_half1: addr=%h siz=%b rw=%b busreq=%b wd=%h, required 000100 01 0 1 AABB",
                                  cq_addr[0], cq_siz[0], cq_rw[0], cq_breq[0], cq_wd[0][15:0]);
            end
            n_cmp++;
            if ({cq_addr[1], cq_siz[1], cq_rw[1], cq_breq[1], cq_wd[1][15:0]} !== {24'h000102, 2'b01, 1'b0, 1'b1, 16'hCCDD}) begin
                n_bad++; $display("FAIL sw_half2: addr=%h siz=%b rw=%b busreq=%b wd=%h, required 000102 01 0 1 CCDD",
                                  cq_addr[1], cq_siz[1], cq_rw[1], cq_breq[1], cq_wd[1][15:0]);
            end
        end
        n_cmp++;
        if (ack_port.size() !== 1 || rd !== 32'h0) begin
            n_bad++; $display("FAIL sw_ack: %0d acks rdata=%h, required 1 ack rdata=00000000", ack_port.size(), rd);
        end
    endtask

    task automatic test_starve();
        int exp_ord[$];
        int r0, r1, streak, low0, low1;
        dsp16 = 1'b0; mem_lat = 0; gnt_delay = 0;
        r0 = 8; r1 = 2; streak = 0; low0 = 0; low1 = 0;
        while (r0 + r1 > 0) begin
            if (r1 > 0 && (r0 == 0 || streak == STARVE)) begin
                exp_ord.push_back(1); r1--; streak = 0;
            end else begin
                exp_ord.push_back(0); r0--;
                if (r1 > 0) streak++;
            end
        end
        clear_q(); ack_port.delete();
        @(negedge sys_clk);
        fork
            begin
                logic [31:0] rd; int cyc; bit ok;
                for (int i = 0; i < 8; i++) begin
                    drive(0, 1'($urandom), 2'($urandom_range(0, 2)), 24'h000200 + 24'(i * 4), $urandom);
                    wait_ack(0, 100, rd, cyc, ok);
                end
            end
            begin
                logic [31:0] rd; int cyc; bit ok;
                for (int i = 0; i < 2; i++) begin
                    drive(1, 1'b1, 2'b10, 24'h004000 + 24'(i * 4), 32'h0);
                    wait_ack(1, 200, rd, cyc, ok);
                end
            end
            begin
                int g;
                g = 0;
                while (ack_port.size() < 1 && g < 400) begin @(negedge sys_clk); g++; end
                low0 = busreq_low;
                while (ack_port.size() < 10 && g < 400) begin @(negedge sys_clk); g++; end
                low1 = busreq_low;
            end
        join
        n_cmp++;
        if (ack_port.size() !== exp_ord.size()) begin
            n_bad++; $display("FAIL starve_count: %0d grants, required %0d", ack_port.size(), exp_ord.size());
        end else begin
            for (int i = 0; i < exp_ord.size(); i++) begin
                n_cmp++;
                if (ack_port[i] !== exp_ord[i]) begin
                    n_bad++; $display("FAIL starve_order[%0d]: port %0d, required port %0d", i, ack_port[i], exp_ord[i]);
                end
            end
        end
        n_cmp++;
        if (low1 - low0 !== 0) begin
            n_bad++; $display("FAIL starve_busreq: busreq low %0d cycles during burst, required 0", low1 - low0);
        end
    endtask

    task automatic test_split_read_wrap();
        logic [31:0] rd; int cyc; bit ok;
        dsp16 = 1'b1; bigend = 1'b0; mem_lat = 1; gnt_delay = 1;
        clear_q();
        @(negedge sys_clk);
        drive(1, 1'b1, 2'b10, 24'hFFFFFE, 32'h0);
        wait_ack(1, 60, rd, cyc, ok);
        n_cmp++;
        if (cq_addr.size() !== 2) begin
            n_bad++; $display("FAIL wrap_ncyc: %0d memory cycles, required 2", cq_addr.size());
        end else begin
            n_cmp++;
            if ({cq_addr[0], cq_addr[1], cq_siz[0], cq_siz[1], cq_rw[0], cq_rw[1]} !== {24'hFFFFFE, 24'h000000, 4'b0101, 2'b11}) begin
                n_bad++; $display("FAIL wrap_addr: %h/%h siz=%b/%b rw=%b/%b, required FFFFFE/000000 01/01 1/1",
                                  cq_addr[0], cq_addr[1], cq_siz[0], cq_siz[1], cq_rw[0], cq_rw[1]);
            end
            n_cmp++;
            if (rd !== {cq_rd[1][15:0], cq_rd[0][15:0]}) begin
                n_bad++; $display("FAIL wrap_rdata: %h, required %h", rd, {cq_rd[1][15:0], cq_rd[0][15:0]});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int cyc, g, n_ack; bit ok;
        dsp16 = 1'b1; bigend = 1'b1; mem_lat = 3; gnt_delay = 0;
        clear_q(); ack_port.delete();
        @(negedge sys_clk);
        drive(1, 1'b1, 2'b10, 24'hFFFFFE, 32'h0);
        g = 0;
        while (!(bus.mreq && bus.msiz == 2'b01 && bus.maddr == 24'h000000) && g < 100) begin
            @(negedge sys_clk); g++;
        end
        n_cmp++;
        if (g >= 100) begin
            n_bad++; $display("FAIL rst_reach_half2: second half not seen in %0d cycles, required it", g);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.mreq, bus.mrw, bus.msiz, bus.maddr, bus.mwdata, bus.ack_0, bus.ack_1, bus.rdata, bus.busreq} !== '0) begin
            n_bad++; $display("FAIL rst_mid_outputs: mreq=%b maddr=%h ack=%b%b busreq=%b, required all 0",
                              bus.mreq, bus.maddr, bus.ack_0, bus.ack_1, bus.busreq);
        end
        bus.req_1 = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_ack = ack_port.size();
        n_cmp++;
        if (n_ack !== 0) begin
            n_bad++; $display("FAIL rst_mid_noack: %0d acks after abandoned transfer, required 0", n_ack);
        end
        clear_q();
        use_fix = 1; rd_fix = $urandom; mem_lat = 1;
        drive(0, 1'b1, 2'b01, 24'hF10020, 32'h0);
        wait_ack(0, 40, rd, cyc, ok);
        n_cmp++;
        if (rd !== rd_fix || cq_addr.size() !== 1) begin
            n_bad++; $display("FAIL rst_recover: rdata=%h cycles=%0d, required %h and 1", rd, cq_addr.size(), rd_fix);
        end
        use_fix = 0;
    endtask

    task automatic test_spurious_mack();
        logic [31:0] rd; int cyc, bad_mreq; bit ok;
        ack_port.delete(); clear_q();
        bad_mreq = 0;
        @(negedge sys_clk);
        spur = 1;
        repeat (4) begin
            @(negedge sys_clk);
            if (bus.mreq || bus.busreq) bad_mreq++;
        end
        n_cmp++;
        if (ack_port.size() !== 0 || bad_mreq !== 0) begin
            n_bad++; $display("FAIL spur_ignored: acks=%0d active cycles=%0d, required 0 and 0", ack_port.size(), bad_mreq);
        end
        mem_lat = 1;
        drive(0, 1'b1, 2'b00, 24'hF17FFF, 32'h0);
        wait_ack(0, 40, rd, cyc, ok);
        n_cmp++;
        if (cyc !== mem_lat + 2 || cq_addr.size() !== 1) begin
            n_bad++; $display("FAIL spur_after: latency=%0d cycles=%0d, required %0d and 1", cyc, cq_addr.size(), mem_lat + 2);
        end
    endtask

    task automatic test_random();
        mem_rand_lat = 1;
        for (int t = 0; t < 40; t++) begin
            int p, cyc;
            logic rw, d16, be;
            logic [1:0] siz;
            logic [23:0] a;
            logic [31:0] wd, rd, exp_rd;
            bit ok, split;
            @(negedge sys_clk);
            p   = $urandom_range(0, 1);
            rw  = (p == 1) ? 1'b1 : 1'($urandom);
            siz = 2'($urandom_range(0, 2));
            a   = ($urandom_range(0, 2) == 0) ? {9'h1E2, 15'($urandom)} : rand_ext();
            wd  = $urandom;
            d16 = 1'($urandom); be = 1'($urandom);
            dsp16 = d16; bigend = be;
            gnt_delay = $urandom_range(0, 3);
            steal = ($urandom_range(0, 3) == 0);
            if (steal) fork
                begin repeat ($urandom_range(1, 4)) @(negedge sys_clk); steal = 0; end
            join_none
            clear_q();
            drive(p, rw, siz, a, wd);
            wait_ack(p, 80, rd, cyc, ok);
            split = d16 && !is_int(a) && siz == 2'b10;
            n_cmp++;
            if (cq_addr.size() !== (split ? 2 : 1)) begin
                n_bad++; $display("FAIL rnd_ncyc[%0d]: %0d memory cycles, required %0d", t, cq_addr.size(), split ? 2 : 1);
            end else begin
                n_cmp++;
                if ({cq_addr[0], cq_siz[0], cq_rw[0], cq_breq[0]} !== {a, split ? 2'b01 : siz, rw, !is_int(a)}) begin
                    n_bad++; $display("FAIL rnd_cyc0[%0d]: addr=%h siz=%b rw=%b busreq=%b, required %h %b %b %b", t,
                                      cq_addr[0], cq_siz[0], cq_rw[0], cq_breq[0], a, split ? 2'b01 : siz, rw, !is_int(a));
                end
                if (split) begin
                    n_cmp++;
                    if ({cq_addr[1], cq_siz[1], cq_rw[1], cq_breq[1]} !== {a + 24'd2, 2'b01, rw, 1'b1}) begin
                        n_bad++; $display("FAIL rnd_cyc1[%0d]: addr=%h siz=%b rw=%b busreq=%b, required %h 01 %b 1", t,
                                          cq_addr[1], cq_siz[1], cq_rw[1], cq_breq[1], a + 24'd2, rw);
                    end
                end
                if (!rw) begin
                    n_cmp++;
                    if (split ? ({cq_wd[0][15:0], cq_wd[1][15:0]} !== (be ? wd : {wd[15:0], wd[31:16]}))
                              : (cq_wd[0] !== wd)) begin
                        n_bad++; $display("FAIL rnd_wdata[%0d]: %h/%h, required data %h split=%0d bigend=%0d", t,
                                          cq_wd[0], split ? cq_wd[1] : 32'h0, wd, split, be);
                    end
                end
                if (!rw)        exp_rd = 32'h0;
                else if (!split) exp_rd = cq_rd[0];
                else if (be)    exp_rd = {cq_rd[0][15:0], cq_rd[1][15:0]};
                else            exp_rd = {cq_rd[1][15:0], cq_rd[0][15:0]};
                n_cmp++;
                if (rd !== exp_rd) begin
                    n_bad++; $display("FAIL rnd_rdata[%0d]: %h, required %h", t, rd, exp_rd);
                end
            end
        end
        steal = 0;
        mem_rand_lat = 0;
    endtask

    initial begin
        reset = 1'b1; dsp16 = 1'b0; bigend = 1'b0;
        bus.req_0 = 1'b0; bus.req_1 = 1'b0; bus.rw_0 = 1'b0; bus.rw_1 = 1'b1;
        bus.siz_0 = 2'b00; bus.siz_1 = 2'b00; bus.addr_0 = '0; bus.addr_1 = '0; bus.wdata_0 = '0;
        test_reset();
        test_internal();
        test_split_write();
        test_starve();
        test_split_read_wrap();
        test_reset_mid();
        test_spurious_mack();
        test_random();
        repeat (2) @(negedge sys_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/j_jmemarb.md
Name: j_jmemarb

Overview:
- Arbiter and sequencer in front of the DSP external memory interface controller.
- Shares the single memory port between two requesters: DSP data load/store (port 0) and instruction prefetch (port 1).
- Acquires external bus ownership before issuing external cycles.
- When the external bus is configured 16-bit, splits 32-bit accesses into two halves.
- Sits between the DSP core/prefetch queue and the memory interface controller; drives that controller's mreq/rw/size/address inputs and consumes its ack.

Parameters:
- AW, 24, address width.
- STARVE, 4, consecutive port-0 grants allowed while port 1 waits before port 1 is forced.
- INT_PAGE, 9'h1E2, value of addr[23:15] that marks DSP-internal space (F10000-F17FFF); internal accesses need no bus ownership.

Ports:
- sys_clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- dsp16  in  1  external bus is 16-bit; long accesses are split
- bigend  in  1  big-endian half ordering
- req_0, req_1  in  1  request; held until matching ack
- rw_0, rw_1  in  1  1 = read, 0 = write
- siz_0, siz_1  in  2  00 byte, 01 word, 10 long
- addr_0, addr_1  in  AW  byte address
- wdata_0  in  32  write data (port 1 is read-only; rw_1 must be 1)
- ack_0, ack_1  out  1  one-cycle completion pulse
- rdata  out  32  read data, valid when ack_0 or ack_1 = 1
- mreq  out  1  memory cycle request to the controller
- mrw  out  1  direction to the controller
- msiz  out  2  size to the controller
- maddr  out  AW  address to the controller
- mwdata  out  32  write data to the controller
- mack  in  1  controller completion, one-cycle pulse
- mrdata  in  32  controller read data, valid with mack
- busreq  out  1  external bus request
- busgnt  in  1  external bus granted

Behaviour:
- Reset: all outputs 0; state IDLE; starvation counter 0; bus not owned. Reset asserted mid-transfer abandons the transfer with no ack.
- States: IDLE, BUSREQ, ISSUE, HALF2, DONE.
- Arbitration happens in IDLE only.
  - Port 0 wins when both ports request, unless the starvation counter equals STARVE; then port 1 wins.
  - The counter increments on each port-0 grant while req_1 = 1.
  - The counter clears on any port-1 grant, or when req_1 = 0.
  - The counter saturates at STARVE.
- Winner's rw/siz/addr/wdata are latched at grant; requester inputs are then ignored until ack.
- Internal access (addr[23:15] == INT_PAGE): IDLE -> ISSUE directly.
- External access:
  - Bus already owned (busgnt = 1 and busreq = 1): IDLE -> ISSUE.
  - Otherwise IDLE -> BUSREQ with busreq = 1; remain until busgnt = 1, then -> ISSUE.
- ISSUE: mreq = 1 with latched fields, held until mack = 1.
  - Split case (dsp16 = 1, external, long): first half uses msiz = 01 at maddr = addr, then -> HALF2.
  - Otherwise, on mack -> DONE.
- HALF2: mreq = 1, msiz = 01, maddr = addr + 2 (wraps modulo 2^AW); on mack -> DONE.
  - Half ordering, bigend = 1: first half = bits 31:16, second half = bits 15:0. bigend = 0 reverses this.
  - Reads: each half is taken from mrdata[15:0].
  - Writes: the half is placed on mwdata[15:0].
- mreq drops in the cycle after mack. mack arriving while mreq = 0 is ignored.
- DONE: ack_n = 1 for exactly one cycle with rdata valid (writes: rdata = 0); -> IDLE.
  - Grant-to-ack latency, unsplit: 1 + (BUSREQ wait) + controller latency + 1.
- Bus release: busreq stays 1 through DONE. In IDLE, busreq drops if the next granted access is internal or no request is pending. A pending external request keeps ownership (back-to-back external cycles).
- busgnt deasserted while owned (external steal): an in-flight cycle finishes. A new external access re-enters BUSREQ.
- Never more than one ack per cycle. ack_n is never asserted without a prior grant to port n.

Test Plan:
- req_0 read long internal addr F10004, mack after 2 cycles, mrdata = 12345678 -> busreq stays 0; single mreq with msiz = 10; ack_0 one cycle; rdata = 12345678.
- dsp16 = 1, bigend = 1, port-0 write long external addr 000100, wdata_0 = AABBCCDD, busgnt after 3 cycles -> busreq rises first; mreq at 000100 with mwdata[15:0] = AABB, then at 000102 with CCDD; one ack_0.
- req_0 and req_1 both held continuously, all external -> grant order 0,0,0,0,1,0,0,0,0,1; busreq never drops.
- dsp16 = 1, bigend = 0, port-1 read long at addr FFFFFE -> second half at 000000; rdata = {second mrdata[15:0], first mrdata[15:0]}.
- reset pulsed while in HALF2 -> all outputs 0 immediately; no ack; after release, a new req_0 completes normally.
- spurious mack in IDLE -> ignored; no ack and no state change.
